pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Sequencing controller for the decode→execute→writeback pipeline. Drives the enable of the ID/EX pipeline buffer and the PC/IF-ID enables, and inserts bubbles by forcing the buffered write-enable low. Tracks in-flight register writes to detect read-after-write hazards and stalls decode until the hazard clears. The ID/EX buffer has no reset, so after reset this block also flushes the pipeline with bubbles.

## Interface
- ADDR_W, 5, register-file address width
- WB_LAT, 2, cycles from ID/EX capture until the register-file write is readable by decode (1..4)
- CNT_W, 16, width of the stall performance counter
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs1, id_rs2  in  ADDR_W  source registers
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  ADDR_W  destination register
- id_we  in  1  instruction writes rd
- ext_stall  in  1  global freeze request (memory/IO busy)
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID buffer enable
- idex_en  out  1  ID/EX buffer enable (to buffer EN)
- idex_bubble  out  1  when 1, write-enable into ID/EX buffer is forced to 0
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- States: FLUSH, RUN, FROZEN.
- FLUSH (entered on reset): pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1 for WB_LAT cycles; flush counter then expires → RUN.
- RUN: hazard = id_valid and any valid tracker entry with rd≠0 matching id_rs1, or matching id_rs2 when id_use_rs2.
  - No hazard: pc_en=1, ifid_en=1, idex_en=1, idex_bubble=!id_valid.
  - Hazard: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1; stall_cnt increments (saturates at all-ones).
  - ext_stall=1 → FROZEN in the same cycle (combinational outputs already frozen).
- FROZEN: all three enables 0, idex_bubble=0, tracker and stall_cnt hold. Leaves to RUN in the cycle ext_stall deasserts; that cycle is evaluated as RUN.
- ext_stall during FLUSH: ignored; FLUSH completes, then FROZEN if still asserted.
- Tracker: WB_LAT-deep shift register of {v, rd}. Shifts when idex_en=1; entry in = {id_valid & id_we & !idex_bubble & rd≠0, id_rd}; oldest entry drops out. Holds when idex_en=0.
- Register 0 never creates a hazard; rd=0 writes are not tracked.
- Hazard check uses tracker contents before this cycle's shift.

## Timing
- Outputs are combinational from state, tracker and inputs; state, tracker, flush counter and stall_cnt are registered.
- Reset values (rst_n=0 sampled at clk edge): state=FLUSH, flush count=0, tracker all invalid, stall_cnt=0; hence pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1.
- Reset mid-operation discards the tracker and restarts FLUSH; stall_cnt clears.
- A dependent instruction directly behind its producer stalls exactly WB_LAT cycles; a gap of k independent instructions reduces the stall to max(0, WB_LAT−k).
- Back-to-back hazards chain without idle cycles; each stall cycle counts once.

## Structure
- Shared package pipe_pkg: state enum (FLUSH, RUN, FROZEN), ADDR_W default, WB_LAT range constants.
- One natural sub-module: wr_tracker (the shift register plus parallel rs1/rs2 compare, outputs hazard).
- Top holds the FSM, flush counter, stall counter and output decode.

## Test plan
- Reset, then hold id_valid=0, WB_LAT=2 → exactly 2 cycles of idex_bubble=1, pc_en=0, then RUN with pc_en=1.
- Issue write x5 followed immediately by read rs1=x5 → 2 stall cycles (pc_en=0, idex_bubble=1), stall_cnt=2, then issue.
- Write x0 followed by read x0 → no stall, stall_cnt unchanged.
- Write x7, one independent instruction, read rs2=x7 with id_use_rs2=1 → 1 stall cycle; with id_use_rs2=0 → none.
- ext_stall=1 for 3 cycles during a hazard stall → enables 0, tracker and stall_cnt held; hazard resolves after release with remaining stall cycles intact.
- rst_n low during a stall → next cycle in FLUSH, stall_cnt=0, pending hazard dropped.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } pipe_state_t;

  localparam int ADDR_W_DEF  = 5;
  localparam int WB_LAT_MIN  = 1;
  localparam int WB_LAT_MAX  = 4;
  // Wide enough to count up to WB_LAT_MAX-1 flush cycles.
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/wr_tracker.sv
// rtl/wr_tracker.sv - in-flight register write tracker with RAW hazard compare
module wr_tracker
  import pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              in_v,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              use_rs2,
  output logic              hazard
);

  logic              v_q  [DEPTH];
  logic [ADDR_W-1:0] rd_q [DEPTH];

  // Shift a new {v, rd} entry in whenever the ID/EX buffer advances; the oldest falls out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i]  <= 1'b0;
        rd_q[i] <= '0;
      end
    end else if (shift_en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        v_q[i]  <= v_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
      v_q[0]  <= in_v;
      rd_q[0] <= in_rd;
    end
  end

  // Compare every pending write against the decode sources; x0 never matches.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i] && (rd_q[i] != '0) &&
          ((rd_q[i] == rs1) || (use_rs2 && (rd_q[i] == rs2)))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - decode/execute sequencing: flush, RAW stall, freeze
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_use_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_we,
  input  logic              ext_stall,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Keep the latency inside the range the flush counter and tracker are built for.
  localparam int LAT = (WB_LAT < WB_LAT_MIN) ? WB_LAT_MIN :
                       (WB_LAT > WB_LAT_MAX) ? WB_LAT_MAX : WB_LAT;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(LAT - 1);

  pipe_state_t             state_q;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q;
  logic [CNT_W-1:0]        stall_cnt_q;
  logic                    trk_hit;
  logic                    hazard;
  logic                    trk_in_v;

  // Only instructions that really enter execute and write a nonzero register are tracked.
  assign trk_in_v = id_valid && id_we && !idex_bubble && (id_rd != '0);

  wr_tracker #(
    .ADDR_W (ADDR_W),
    .DEPTH  (LAT)
  ) u_wr_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (idex_en),
    .in_v     (trk_in_v),
    .in_rd    (id_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .use_rs2  (id_use_rs2),
    .hazard   (trk_hit)
  );

  // A counted stall needs a running pipeline (not flushing, not frozen this cycle).
  assign hazard = (state_q != FLUSH) && !ext_stall && id_valid && trk_hit;

  // Output decode; ext_stall freezes combinationally so RUN->FROZEN takes effect at once.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b1;
    if (state_q != FLUSH) begin
      if (ext_stall) begin
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
      end else if (!hazard) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_bubble = !id_valid;
      end
    end
  end

  // State machine: WB_LAT flush cycles after reset, then RUN/FROZEN follow ext_stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q     <= ext_stall ? FROZEN : RUN;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        RUN, FROZEN: state_q <= ext_stall ? FROZEN : RUN;
        default:     state_q <= FLUSH;
      endcase
    end
  end

  // Saturating count of hazard stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int ADDR_W = 5;
  localparam int WB_LAT = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_use_rs2;
  logic [ADDR_W-1:0] id_rd;
  logic              id_we;
  logic              ext_stall;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .ADDR_W (ADDR_W),
    .WB_LAT (WB_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .ext_stall   (ext_stall),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .idex_bubble (idex_bubble),
    .stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic             pc;
    logic             ifid;
    logic             idex;
    logic             bub;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Timestamp model: a register is unreadable while fewer than WB_LAT+1 advances
  // have passed since its producer entered execute.
  int m_flush_left;
  int m_adv;
  int m_stall;
  int m_last_wr[32];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_left = WB_LAT;
    m_adv        = 0;
    m_stall      = 0;
    for (int i = 0; i < 32; i++) m_last_wr[i] = -1000;
  endtask

  function automatic logic busy(input logic [ADDR_W-1:0] r);
    return (r != '0) && ((m_adv - m_last_wr[r]) <= WB_LAT);
  endfunction

  task automatic step(input logic v, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                      input logic u2, input logic [ADDR_W-1:0] rd, input logic we,
                      input logic ext, output logic pc_o);
    exp_t e;
    exp_t got;
    logic adv;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_we = we; ext_stall = ext;
    e.cnt = CNT_W'(m_stall);
    adv   = 1'b1;
    if (m_flush_left > 0) begin
      e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b1; e.bub = 1'b1;
      m_flush_left--;
    end else if (ext) begin
      e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b0; e.bub = 1'b0;
      adv = 1'b0;
    end else if (v && (busy(r1) || (u2 && busy(r2)))) begin
      e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b1; e.bub = 1'b1;
      if (m_stall < (1 << CNT_W) - 1) m_stall++;
    end else begin
      e.pc = 1'b1; e.ifid = 1'b1; e.idex = 1'b1; e.bub = !v;
      if (v && we && rd != '0) m_last_wr[rd] = m_adv;
    end
    if (adv) m_adv++;
    sb.push_back(e);
    pc_o = e.pc;
    #4;
    got = sb.pop_front();
    check("pc_en", 32'(pc_en), 32'(got.pc));
    check("ifid_en", 32'(ifid_en), 32'(got.ifid));
    check("idex_en", 32'(idex_en), 32'(got.idex));
    check("idex_bubble", 32'(idex_bubble), 32'(got.bub));
    check("stall_cnt", 32'(stall_cnt), 32'(got.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2, input logic u2,
                       input logic [ADDR_W-1:0] rd, input logic we, output int stalls);
    logic pc;
    pc     = 1'b0;
    stalls = 0;
    for (int i = 0; i < 16 && !pc; i++) begin
      step(1'b1, r1, r2, u2, rd, we, 1'b0, pc);
      if (!pc) stalls++;
    end
    check("issue_done", 32'(pc), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs2 = 1'b0;
    id_rd = '0; id_we = 1'b0; ext_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int   st;
    logic p0, p1, p2, p3, p4;

    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs2 = 1'b0;
    id_rd = '0; id_we = 1'b0; ext_stall = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    #3;
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_bubble", 32'(idex_bubble), 32'd1);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    #1;

    // Flush length with idle decode
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, p0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, p1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, p2);
    check("flush_pc_seq", 32'({p0, p1, p2}), 32'b001);

    // Back-to-back dependency on x5
    issue(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, st);
    check("x5_prod_stalls", 32'(st), 32'd0);
    issue(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, st);
    check("x5_stalls", 32'(st), 32'd2);
    check("x5_cnt", 32'(stall_cnt), 32'd2);

    // x0 never hazards
    issue(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, st);
    issue(5'd0, 5'd0, 1'b1, 5'd1, 1'b0, st);
    check("x0_stalls", 32'(st), 32'd0);
    check("x0_cnt", 32'(stall_cnt), 32'd2);

    // One-instruction gap, rs2 used / unused
    issue(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, st);
    issue(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, st);
    issue(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, st);
    check("x7_rs2_stalls", 32'(st), 32'd1);
    issue(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, st);
    issue(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, st);
    issue(5'd0, 5'd7, 1'b0, 5'd0, 1'b0, st);
    check("x7_nors2_stalls", 32'(st), 32'd0);
    check("x7_cnt", 32'(stall_cnt), 32'd3);

    // Freeze in the middle of a hazard stall
    issue(5'd0, 5'd0, 1'b0, 5'd9, 1'b1, st);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, p0);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, p1);
    check("frz_cnt_held", 32'(stall_cnt), 32'd4);
    issue(5'd9, 5'd0, 1'b0, 5'd0, 1'b0, st);
    check("frz_remaining_stalls", 32'(st), 32'd1);
    check("frz_cnt", 32'(stall_cnt), 32'd5);

    // Reset during a stall drops the pending write
    issue(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, st);
    step(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, p0);
    do_reset();
    #3;
    check("rst2_pc_en", 32'(pc_en), 32'd0);
    check("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
    #1;
    issue(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, st);
    check("rst2_flush_only", 32'(st), 32'd2);
    check("rst2_cnt", 32'(stall_cnt), 32'd0);

    // ext_stall during flush: flush completes, then frozen
    do_reset();
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, p0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, p1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, p2);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, p3);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, p4);
    check("flush_ext_pc_seq", 32'({p0, p1, p2, p3, p4}), 32'b00001);
    check("flush_ext_idex_en", 32'(idex_en), 32'd1);

    // Random traffic on a small register set
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), p0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
